// File: rtl/timekeeper_bcd_pkg.sv
// Shared types and constants for the time-of-day counter.
// Optional alarm support is selected with `define TIMEKEEPER_ALARM_EN.
package timekeeper_pkg;

`ifdef TIMEKEEPER_ALARM_EN
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        RUN       = 3'd0,
        SET_HOUR  = 3'd1,
        SET_MIN   = 3'd2,
        SET_SEC   = 3'd3,
        SET_ALM_H = 3'd4,
        SET_ALM_M = 3'd5
    } edit_state_e;
`else
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } edit_state_e;
`endif

    // BCD limits
    localparam logic [7:0] BCD_MAX_MS      = 8'h59;
    localparam logic [7:0] BCD_MAX_H24     = 8'h23;
    localparam logic [7:0] BCD_MAX_H12     = 8'h12;
    localparam logic [7:0] BCD_H12_PRENOON = 8'h11;

    // Reset time per mode
    localparam logic [7:0] RST_MS      = 8'h00;
    localparam logic [7:0] RST_HOUR_24 = 8'h00;
    localparam logic [7:0] RST_HOUR_12 = 8'h12;

    // Hour/minute/pm triple, used for the alarm setting
    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic       pm;
    } hm_t;

    // Packed-BCD +1 without range check; callers handle their own wrap.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Next hour value with the mode's wrap; 12h runs 12,01..11 and 11->12
    // is where pm flips (handled by the caller).
    function automatic logic [7:0] hour_next(input logic [7:0] h, input logic h12);
        if (h12) begin
            if (h == BCD_MAX_H12) return 8'h01;
            return bcd_inc(h);
        end
        if (h == BCD_MAX_H24) return RST_HOUR_24;
        return bcd_inc(h);
    endfunction

endpackage

// File: rtl/timekeeper_bcd_if.sv
// Button inputs and display/status outputs of the time-of-day counter.
// TIMEKEEPER_ALARM_EN adds alarm_arm / alarm_out.
interface timekeeper_bcd_if;
    import timekeeper_pkg::*;

    logic               mode_btn;
    logic               inc_btn;
    logic [7:0]         sec_bcd;
    logic [7:0]         min_bcd;
    logic [7:0]         hour_bcd;
    logic               pm;
    logic               tick_1hz;
    logic               day_carry;
    logic [STATE_W-1:0] edit_state;
    logic               blink;

`ifdef TIMEKEEPER_ALARM_EN
    logic               alarm_arm;
    logic               alarm_out;

    modport master (output mode_btn, inc_btn, alarm_arm,
                    input  sec_bcd, min_bcd, hour_bcd, pm, tick_1hz,
                           day_carry, edit_state, blink, alarm_out);
    modport slave  (input  mode_btn, inc_btn, alarm_arm,
                    output sec_bcd, min_bcd, hour_bcd, pm, tick_1hz,
                           day_carry, edit_state, blink, alarm_out);
`else
    modport master (output mode_btn, inc_btn,
                    input  sec_bcd, min_bcd, hour_bcd, pm, tick_1hz,
                           day_carry, edit_state, blink);
    modport slave  (input  mode_btn, inc_btn,
                    output sec_bcd, min_bcd, hour_bcd, pm, tick_1hz,
                           day_carry, edit_state, blink);
`endif

endinterface

// File: rtl/timekeeper_bcd_mod_counter.sv
// Packed-BCD modulo counter MIN_BCD..MAX_BCD with synchronous clear.
// wrap is combinational: high in the cycle an increment rolls MAX->MIN,
// so the next field can count on the same edge.
module bcd_mod_counter #(
    parameter logic [7:0] MAX_BCD = 8'h59,
    parameter logic [7:0] MIN_BCD = 8'h00
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       wrap
);
    import timekeeper_pkg::*;

    assign wrap = inc && !clr && (value == MAX_BCD);

    // clear beats increment
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset)    value <= MIN_BCD;
        else if (clr)  value <= MIN_BCD;
        else if (inc)  value <= (value == MAX_BCD) ? MIN_BCD : bcd_inc(value);
    end

endmodule

// File: rtl/timekeeper_bcd.sv
// Synchronous BCD time-of-day counter: prescaler tick, sec/min/hour fields,
// 12/24h hours with pm flag, set-time FSM, edit blink and midnight day_carry.
// Define TIMEKEEPER_ALARM_EN for the alarm registers and alarm output.
module timekeeper_bcd #(
    parameter int TICK_DIV = 50000000,
    parameter bit HOUR_12  = 1'b0
) (
    input logic             clock_in,
    input logic             reset,
    timekeeper_bcd_if.slave bus
);
    import timekeeper_pkg::*;

    localparam int              PW        = $clog2(TICK_DIV);
    localparam int              QTR       = TICK_DIV / 4;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   Q1        = PW'(QTR - 1);
    localparam logic [PW-1:0]   Q2        = PW'(2 * QTR - 1);
    localparam logic [PW-1:0]   Q3        = PW'(3 * QTR - 1);
    localparam logic [PW-1:0]   Q4        = PW'(4 * QTR - 1);
    localparam logic [7:0]      HOUR_RST  = HOUR_12 ? RST_HOUR_12 : RST_HOUR_24;
    // last hour before the day rolls over (11 pm in 12h mode)
    localparam logic [7:0]      HOUR_LAST = HOUR_12 ? BCD_H12_PRENOON : BCD_MAX_H24;

    edit_state_e   state_q, state_d;
    logic [PW-1:0] presc;
    logic          run, tick, inc_ok, leave_edit, blink_edge;
    logic          sec_inc, sec_clr, sec_wrap, min_inc, min_wrap, hour_inc;
    logic [7:0]    sec, min, hour;
    logic          pm_q, day_carry_q, blink_q;

    assign run        = (state_q == RUN);
    assign tick       = (presc == PRE_LAST);
    assign inc_ok     = bus.inc_btn && !bus.mode_btn;   // mode wins
    assign leave_edit = bus.mode_btn && !run && (state_d == RUN);
    // quarter-second boundaries of the prescaler give a 2 Hz square blink
    assign blink_edge = (presc == Q1) || (presc == Q2) || (presc == Q3) || (presc == Q4);

    // edit-state register
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    // edit-state sequencing on mode_btn
    always_comb begin
        state_d = state_q;
        if (bus.mode_btn) begin
            case (state_q)
                RUN:       state_d = SET_HOUR;
                SET_HOUR:  state_d = SET_MIN;
                SET_MIN:   state_d = SET_SEC;
`ifdef TIMEKEEPER_ALARM_EN
                SET_SEC:   state_d = SET_ALM_H;
                SET_ALM_H: state_d = SET_ALM_M;
                SET_ALM_M: state_d = RUN;
`else
                SET_SEC:   state_d = RUN;
`endif
                default:   state_d = RUN;
            endcase
        end
    end

    // prescaler; restarted on return to RUN so the first second is whole
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset)                  presc <= '0;
        else if (leave_edit || tick) presc <= '0;
        else                         presc <= presc + 1'b1;
    end

    assign sec_inc  = run && tick;
    assign sec_clr  = (state_q == SET_SEC) && inc_ok;
    assign min_inc  = (run && sec_wrap) || ((state_q == SET_MIN) && inc_ok);
    assign hour_inc = (run && min_wrap) || ((state_q == SET_HOUR) && inc_ok);

    bcd_mod_counter #(.MAX_BCD(BCD_MAX_MS), .MIN_BCD(RST_MS)) u_sec (
        .clock_in (clock_in),
        .reset    (reset),
        .inc      (sec_inc),
        .clr      (sec_clr),
        .value    (sec),
        .wrap     (sec_wrap)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_MAX_MS), .MIN_BCD(RST_MS)) u_min (
        .clock_in (clock_in),
        .reset    (reset),
        .inc      (min_inc),
        .clr      (1'b0),
        .value    (min),
        .wrap     (min_wrap)
    );

    // hours and pm; pm flips on 11->12 whether running or editing
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            hour <= HOUR_RST;
            pm_q <= 1'b0;
        end else if (hour_inc) begin
            hour <= hour_next(hour, HOUR_12);
            if (HOUR_12 && (hour == BCD_H12_PRENOON)) pm_q <= ~pm_q;
        end
    end

    // day_carry lands with the rolled-over digits; only running time can roll
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) day_carry_q <= 1'b0;
        else        day_carry_q <= run && min_wrap && (hour == HOUR_LAST) && (!HOUR_12 || pm_q);
    end

    // blink: solid in RUN and on every state change, square wave while editing
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset)                   blink_q <= 1'b1;
        else if (run || bus.mode_btn) blink_q <= 1'b1;
        else if (blink_edge)          blink_q <= ~blink_q;
    end

`ifdef TIMEKEEPER_ALARM_EN
    hm_t        alm;
    logic       alm_active, alm_match;
    logic [5:0] alm_ticks;

    assign alm_match = run && (hour == alm.hour) && (min == alm.min) &&
                       (pm_q == alm.pm) && (sec == RST_MS);

    // alarm time, edited like the clock fields but without carries
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            alm <= '{hour: HOUR_RST, min: RST_MS, pm: 1'b0};
        end else if ((state_q == SET_ALM_H) && inc_ok) begin
            alm.hour <= hour_next(alm.hour, HOUR_12);
            if (HOUR_12 && (alm.hour == BCD_H12_PRENOON)) alm.pm <= ~alm.pm;
        end else if ((state_q == SET_ALM_M) && inc_ok) begin
            alm.min <= (alm.min == BCD_MAX_MS) ? RST_MS : bcd_inc(alm.min);
        end
    end

    // alarm rings for 60 ticks, cut short when disarmed
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            alm_active <= 1'b0;
            alm_ticks  <= '0;
        end else if (!bus.alarm_arm) begin
            alm_active <= 1'b0;
        end else if (alm_active) begin
            if (tick) begin
                alm_ticks <= alm_ticks + 6'd1;
                if (alm_ticks == 6'd59) alm_active <= 1'b0;
            end
        end else if (alm_match) begin
            alm_active <= 1'b1;
            alm_ticks  <= '0;
        end
    end

    assign bus.alarm_out = alm_active;
`endif

    assign bus.sec_bcd    = sec;
    assign bus.min_bcd    = min;
    assign bus.hour_bcd   = hour;
    assign bus.pm         = HOUR_12 ? pm_q : 1'b0;
    assign bus.tick_1hz   = tick;
    assign bus.day_carry  = day_carry_q;
    assign bus.edit_state = state_q;
    assign bus.blink      = blink_q;

endmodule

// File: tb/tb_timekeeper_bcd.sv
// Bench for timekeeper_bcd: a 24h and a 12h instance share clock, reset and
// buttons, and both are compared every cycle against one integer time model.
module tb_timekeeper_bcd;
    localparam int TD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timekeeper_bcd_if bus24 ();
    timekeeper_bcd_if bus12 ();

    timekeeper_bcd #(.TICK_DIV(TD), .HOUR_12(1'b0)) dut24 (.clock_in(clk), .reset(rst_n), .bus(bus24));
    timekeeper_bcd #(.TICK_DIV(TD), .HOUR_12(1'b1)) dut12 (.clock_in(clk), .reset(rst_n), .bus(bus12));

    int checks = 0;
    int errors = 0;

    // model: time kept as plain 0..23 / 0..59 integers; 12h view derived
    int m_h, m_m, m_s, m_presc, m_state;
    bit m_blink, m_dc;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [7:0] hour_disp(input int h, input bit h12);
        int v;
        v = h12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
        return to_bcd(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_presc = 0; m_state = 0; m_blink = 1'b1; m_dc = 1'b0;
    endtask

    // one clock edge of behaviour, using the inputs present at that edge
    task automatic model_step(input bit mode, input bit inc);
        bit tick;
        int ost;
        tick = (m_presc == TD - 1);
        ost  = m_state;
        m_dc = 1'b0;
        if (ost == 0 && tick) begin
            m_s++;
            if (m_s == 60) begin
                m_s = 0; m_m++;
                if (m_m == 60) begin
                    m_m = 0; m_h++;
                    if (m_h == 24) begin m_h = 0; m_dc = 1'b1; end
                end
            end
        end else if (ost != 0 && inc && !mode) begin
            case (ost)
                1: m_h = (m_h + 1) % 24;
                2: m_m = (m_m + 1) % 60;
                default: m_s = 0;
            endcase
        end
        m_presc = (mode && ost == 3) ? 0 : (m_presc + 1) % TD;
        if (mode) m_state = (ost + 1) % 4;
        // at TICK_DIV=4 the blink quarter-period is one cycle
        m_blink = (mode || ost == 0) ? 1'b1 : !m_blink;
    endtask

    task automatic check_one(input string tag, input bit h12,
                             input logic [7:0] s, input logic [7:0] mi, input logic [7:0] ho,
                             input logic p, input logic t, input logic dc,
                             input logic [1:0] st, input logic bl);
        chk({tag, " sec"},   s,  to_bcd(m_s));
        chk({tag, " min"},   mi, to_bcd(m_m));
        chk({tag, " hour"},  ho, hour_disp(m_h, h12));
        chk({tag, " pm"},    p,  h12 && (m_h >= 12));
        chk({tag, " tick"},  t,  m_presc == TD - 1);
        chk({tag, " dcar"},  dc, m_dc);
        chk({tag, " state"}, st, m_state);
        chk({tag, " blink"}, bl, m_blink);
    endtask

    task automatic check_model();
        check_one("h24", 1'b0, bus24.sec_bcd, bus24.min_bcd, bus24.hour_bcd, bus24.pm,
                  bus24.tick_1hz, bus24.day_carry, bus24.edit_state, bus24.blink);
        check_one("h12", 1'b1, bus12.sec_bcd, bus12.min_bcd, bus12.hour_bcd, bus12.pm,
                  bus12.tick_1hz, bus12.day_carry, bus12.edit_state, bus12.blink);
    endtask

    task automatic set_in(input bit mode, input bit inc);
        bus24.mode_btn = mode; bus24.inc_btn = inc;
        bus12.mode_btn = mode; bus12.inc_btn = inc;
    endtask

    task automatic step(input bit mode, input bit inc);
        set_in(mode, inc);
        @(posedge clk);
        model_step(mode, inc);
        #1;
        check_model();
    endtask

    // from RUN: edit hour and minute, clear seconds, back to RUN
    task automatic set_time(input int h, input int mi);
        step(1, 0);
        for (int k = 0; k < 24 && m_h != h; k++) step(0, 1);
        step(1, 0);
        for (int k = 0; k < 60 && m_m != mi; k++) step(0, 1);
        step(1, 0);
        step(0, 1);
        step(1, 0);
        chk("set_time hour", bus24.hour_bcd, to_bcd(h));
        chk("set_time min",  bus24.min_bcd,  to_bcd(mi));
        chk("set_time sec",  bus24.sec_bcd,  8'h00);
    endtask

    // run until the next edge is the tick that leaves second 59
    task automatic run_to_rollover();
        int n;
        n = 0;
        while (!(m_s == 59 && m_presc == TD - 1) && n < 400) begin
            step(0, 0);
            n++;
        end
        chk("reach second 59 within bound", n < 400, 1'b1);
    endtask

    typedef struct {
        bit    mode;
        bit    inc;
        int    st;
        int    h;
        int    mi;
        int    s;
        string name;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, toggles, h_save, s_save;
        logic prev_blink;

        // FSM walk starting from 00:01:05 in RUN with the prescaler at 0
        vecs[0]  = '{0, 1, 0, 0, 1, 5, "inc in RUN ignored"};
        vecs[1]  = '{1, 0, 1, 0, 1, 5, "RUN->SET_HOUR"};
        vecs[2]  = '{0, 1, 1, 1, 1, 5, "hour inc"};
        vecs[3]  = '{1, 1, 2, 1, 1, 5, "mode beats inc"};
        vecs[4]  = '{0, 1, 2, 1, 2, 5, "min inc"};
        vecs[5]  = '{0, 1, 2, 1, 3, 5, "min inc 2"};
        vecs[6]  = '{1, 0, 3, 1, 3, 5, "SET_MIN->SET_SEC"};
        vecs[7]  = '{0, 1, 3, 1, 3, 0, "sec clear"};
        vecs[8]  = '{1, 0, 0, 1, 3, 0, "SET_SEC->RUN"};
        vecs[9]  = '{0, 1, 0, 1, 3, 0, "inc in RUN again"};
        vecs[10] = '{0, 0, 0, 1, 3, 0, "idle after restart"};

        // reset values
        set_in(0, 0);
        model_reset();
        #12;
        check_model();
        chk("rst hour24", bus24.hour_bcd, 8'h00);
        chk("rst hour12", bus12.hour_bcd, 8'h12);
        chk("rst blink",  bus24.blink,    1'b1);
        chk("rst state",  bus12.edit_state, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 240 cycles = 60 seconds
        ticks = 0;
        repeat (240) begin
            step(0, 0);
            if (bus24.tick_1hz) ticks++;
        end
        chk("240cyc sec", bus24.sec_bcd, 8'h00);
        chk("240cyc min", bus24.min_bcd, 8'h01);
        chk("240cyc ticks", ticks, 60);

        repeat (20) step(0, 0);
        chk("pre-table sec", bus24.sec_bcd, 8'h05);

        foreach (vecs[i]) begin
            step(vecs[i].mode, vecs[i].inc);
            chk({"vec ", vecs[i].name, " state"}, bus24.edit_state, vecs[i].st);
            chk({"vec ", vecs[i].name, " hour24"}, bus24.hour_bcd, to_bcd(vecs[i].h));
            chk({"vec ", vecs[i].name, " hour12"}, bus12.hour_bcd, hour_disp(vecs[i].h, 1'b1));
            chk({"vec ", vecs[i].name, " min"}, bus24.min_bcd, to_bcd(vecs[i].mi));
            chk({"vec ", vecs[i].name, " sec"}, bus12.sec_bcd, to_bcd(vecs[i].s));
        end

        // 23:59:59 -> 00:00:00 (12h: 11:59:59 pm -> 12:00:00 am) with day_carry
        set_time(23, 59);
        run_to_rollover();
        step(0, 0);
        chk("midnight hour24", bus24.hour_bcd, 8'h00);
        chk("midnight min",    bus24.min_bcd,  8'h00);
        chk("midnight sec",    bus24.sec_bcd,  8'h00);
        chk("midnight dc24",   bus24.day_carry, 1'b1);
        chk("midnight hour12", bus12.hour_bcd, 8'h12);
        chk("midnight pm",     bus12.pm,       1'b0);
        chk("midnight dc12",   bus12.day_carry, 1'b1);
        step(0, 0);
        chk("dc single pulse 24", bus24.day_carry, 1'b0);
        chk("dc single pulse 12", bus12.day_carry, 1'b0);

        // 11:59:59 am -> 12:00:00 pm, no day_carry
        set_time(11, 59);
        run_to_rollover();
        step(0, 0);
        chk("noon hour12", bus12.hour_bcd, 8'h12);
        chk("noon pm",     bus12.pm,       1'b1);
        chk("noon dc12",   bus12.day_carry, 1'b0);
        chk("noon hour24", bus24.hour_bcd, 8'h12);

        // SET_MIN wrap without carry; time frozen and blinking
        step(1, 0);
        step(1, 0);
        for (int k = 0; k < 60 && m_m != 59; k++) step(0, 1);
        h_save = m_h;
        s_save = m_s;
        step(0, 1);
        chk("setmin wrap min",  bus24.min_bcd,  8'h00);
        chk("setmin wrap hour", bus24.hour_bcd, to_bcd(h_save));
        ticks = 0;
        toggles = 0;
        prev_blink = bus24.blink;
        repeat (8 * TD) begin
            step(0, 0);
            if (bus24.tick_1hz) ticks++;
            if (bus24.blink != prev_blink) toggles++;
            prev_blink = bus24.blink;
        end
        chk("frozen sec",       bus24.sec_bcd, to_bcd(s_save));
        chk("ticks while edit", ticks, 8);
        chk("blink toggles",    toggles, 8 * TD);
        step(1, 0);
        step(1, 0);

        // reset during SET_HOUR at 07 acts without a clock edge
        step(1, 0);
        for (int k = 0; k < 24 && m_h != 7; k++) step(0, 1);
        chk("edit hour 07", bus24.hour_bcd, 8'h07);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async rst state", bus24.edit_state, 2'd0);
        chk("async rst hour",  bus24.hour_bcd,   8'h00);
        chk("async rst blink", bus24.blink,      1'b1);
        check_model();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized button traffic against the model
        repeat (2000) step($urandom_range(15) == 0, $urandom_range(3) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
